mem_arb_ctrl: RTL and testbench
===============================

// Module: mem_arb_ctrl
// PURPOSE
//  Memory-side controller for the JTAG programming path. Arbitrates one single-port sync SRAM between the
//  JTAG requester (level sel / ready handshake, tck domain) and the CPU requester (req/gnt, sys_clk domain).
//  Sequences each access (issue, read-latency wait, response) and returns read data to the winner.
// PARAMETERS
//  AW           8   address width (JTAG address path is 8 bits)
//  DW           16  data width
//  RD_LAT       1   SRAM read latency in cycles after mem_ce; legal 1..3
//  SYNC_STAGES  2   flop stages on jtag_sel into sys_clk; legal 2..3
// PORTS
//  sys_clk     in   1   system clock; the only clock
//  sys_rst     in   1   synchronous, active-high reset
//  jtag_sel    in   1   JTAG request level; async, from tck domain
//  jtag_we     in   1   1=write; quasi-static while jtag_sel=1
//  jtag_addr   in   AW  quasi-static while jtag_sel=1
//  jtag_wdata  in   DW  quasi-static while jtag_sel=1
//  jtag_ready  out  1   1=idle/done, 0=busy; registered
//  jtag_rdata  out  DW  last JTAG read data; registered, held until next JTAG read
//  cpu_req     in   1   CPU request; held with fields until cpu_gnt
//  cpu_we      in   1   1=write
//  cpu_addr    in   AW
//  cpu_wdata   in   DW
//  cpu_gnt     out  1   1-cycle accept pulse
//  cpu_rvalid  out  1   1-cycle read-data pulse
//  cpu_rdata   out  DW  valid with cpu_rvalid
//  mem_ce      out  1   SRAM access strobe, one cycle per access
//  mem_we      out  1
//  mem_addr    out  AW
//  mem_wdata   out  DW
//  mem_rdata   in   DW  valid RD_LAT cycles after the mem_ce cycle
// BEHAVIOUR
//  Reset: jtag_ready=1; cpu_gnt, cpu_rvalid, mem_ce, mem_we=0; jtag_rdata, cpu_rdata, mem_addr, mem_wdata=0;
//   rr pointer favours JTAG; all FSMs idle. Reset mid-access drops it: no rvalid, jtag_ready=1 next cycle.
//  JTAG side FSM (sel_s = synchronised jtag_sel):
//   J_IDLE  ready=1; sel_s=1 -> latch we/addr/wdata, ready<=0, J_PEND
//   J_PEND  ready=0; request raised to arbiter; granted -> J_BUSY
//   J_BUSY  ready=0; on completion (write: cycle after issue; read: cycle jtag_rdata loads) -> ready<=1, J_REL
//   J_REL   ready=1; sel_s=0 -> J_IDLE; sel_s held 1 never re-triggers an access
//   jtag_rdata loads in the same edge jtag_ready rises; stable thereafter (tck side samples it after sync).
//   After reset with jtag_sel already 1: start in J_IDLE, accept it as a new request.
//  Arbiter FSM:
//   A_IDLE   pick among {JTAG pending, cpu_req}; only one -> it wins; both -> rr pointer (not last winner).
//            Grant: latch cmd into mem_* regs, set owner, flip pointer; CPU win -> cpu_gnt=1 this cycle
//            (combinational from A_IDLE & win). -> A_ISSUE
//   A_ISSUE  mem_ce=1 one cycle; write -> A_IDLE; read -> A_WAIT, cnt=RD_LAT-1
//   A_WAIT   cnt down; at cnt=0 capture mem_rdata into owner's rdata reg -> A_IDLE
//  CPU read timing: gnt at T, mem_ce at T+1, cpu_rvalid/cpu_rdata at T+2+RD_LAT.
//  Peak throughput: write 1 per 2 cycles, read 1 per RD_LAT+2 cycles. No back-pressure on responses.
//  Fairness: continuous cpu_req plus a JTAG request -> JTAG served within one CPU access.
//  cpu_req dropped before gnt: allowed; no access. mem_ce never asserted outside A_ISSUE.
// STRUCTURE
//  mem_arb_pkg: j_state_e, arb_state_e, owner_e {OWN_JTAG, OWN_CPU}, mem_cmd_t {we, addr, wdata}.
//  Sub-module sync_ff #(STAGES): reset-to-0 flop chain for jtag_sel; everything else in mem_arb_ctrl.
// TESTING
//  1 JTAG write sel=1 addr=8'h12 wdata=16'hA5A5 -> ready 0 within SYNC_STAGES+1, one mem_ce we=1 12/A5A5, ready 1
//  2 JTAG read addr=8'h12 (SRAM model) -> jtag_rdata=16'hA5A5 on the edge ready rises; sel held 1 -> no 2nd mem_ce
//  3 RD_LAT=2, CPU read addr=8'h34 (holds 16'h1234), gnt at T -> mem_ce at T+1, cpu_rvalid=1 rdata 16'h1234 at T+4
//  4 JTAG and CPU pending together out of reset -> JTAG first, CPU next; continuous cpu_req + JTAG -> alternating
//  5 sys_rst=1 during A_WAIT of CPU read -> next cycle mem_ce=0, jtag_ready=1; no cpu_rvalid afterwards
//  6 CPU write then CPU read same address back-to-back -> read returns written data; gnt pulses exactly once each

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the JTAG/CPU SRAM arbiter: FSM encodings, access owner and the
// latched memory command.
package mem_arb_pkg;

  localparam int CMD_AW = 8;
  localparam int CMD_DW = 16;

  typedef enum logic [1:0] {J_IDLE, J_PEND, J_BUSY, J_REL} j_state_e;
  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT} arb_state_e;
  typedef enum logic {OWN_JTAG, OWN_CPU} owner_e;

  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_ctrl_sync_ff.sv
// Reset-to-0 flop chain bringing the asynchronous JTAG select level into clk.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (srst) chain <= '0;
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbitrates one single-port sync SRAM between the JTAG programming path and the CPU,
// sequencing issue, read-latency wait and response for each access.
module mem_arb_ctrl
  import mem_arb_pkg::*;
#(
  parameter int AW          = CMD_AW,
  parameter int DW          = CMD_DW,
  parameter int RD_LAT      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          jtag_sel,
  input  logic          jtag_we,
  input  logic [AW-1:0] jtag_addr,
  input  logic [DW-1:0] jtag_wdata,
  output logic          jtag_ready,
  output logic [DW-1:0] jtag_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic       sel_s;
  j_state_e   j_state;
  arb_state_e a_state;
  owner_e     owner;
  mem_cmd_t   jtag_cmd;
  mem_cmd_t   cpu_cmd;
  mem_cmd_t   grant_cmd;
  logic       rr_jtag;
  logic [1:0] cnt;
  logic       jtag_pend, win_jtag, win_cpu, jtag_done;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sel_sync (
    .clk  (sys_clk),
    .srst (sys_rst),
    .d    (jtag_sel),
    .q    (sel_s)
  );

  // rr_jtag=1 means JTAG takes a tie; it always points away from the last winner.
  assign jtag_pend = (j_state == J_PEND);
  assign win_jtag  = !sys_rst && (a_state == A_IDLE) && jtag_pend && (!cpu_req || rr_jtag);
  assign win_cpu   = !sys_rst && (a_state == A_IDLE) && cpu_req && (!jtag_pend || !rr_jtag);
  assign cpu_gnt   = win_cpu;
  assign cpu_cmd   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign grant_cmd = win_jtag ? jtag_cmd : cpu_cmd;
  assign jtag_done = (owner == OWN_JTAG) &&
                     (((a_state == A_ISSUE) && mem_we) || ((a_state == A_WAIT) && (cnt == 2'd0)));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      j_state    <= J_IDLE;
      jtag_ready <= 1'b1;
      jtag_rdata <= '0;
      jtag_cmd   <= '0;
    end else begin
      case (j_state)
        J_IDLE: if (sel_s) begin
          jtag_cmd   <= '{we: jtag_we, addr: jtag_addr, wdata: jtag_wdata};
          jtag_ready <= 1'b0;
          j_state    <= J_PEND;
        end
        J_PEND: if (win_jtag) j_state <= J_BUSY;
        J_BUSY: if (jtag_done) begin
          if (!mem_we) jtag_rdata <= mem_rdata;
          jtag_ready <= 1'b1;
          j_state    <= J_REL;
        end
        // A level still held high after completion must not start a second access.
        J_REL:  if (!sel_s) j_state <= J_IDLE;
        default: j_state <= J_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      a_state    <= A_IDLE;
      owner      <= OWN_JTAG;
      rr_jtag    <= 1'b1;
      cnt        <= '0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      mem_ce     <= 1'b0;
      cpu_rvalid <= 1'b0;
      case (a_state)
        A_IDLE: if (win_jtag || win_cpu) begin
          mem_we    <= grant_cmd.we;
          mem_addr  <= grant_cmd.addr;
          mem_wdata <= grant_cmd.wdata;
          owner     <= win_jtag ? OWN_JTAG : OWN_CPU;
          rr_jtag   <= win_cpu;
          mem_ce    <= 1'b1;
          a_state   <= A_ISSUE;
        end
        A_ISSUE: begin
          if (mem_we) begin
            a_state <= A_IDLE;
          end else begin
            cnt     <= 2'(RD_LAT - 1);
            a_state <= A_WAIT;
          end
        end
        A_WAIT: begin
          if (cnt == 2'd0) begin
            if (owner == OWN_CPU) begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= mem_rdata;
            end
            a_state <= A_IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: a_state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl with an SRAM model and a transaction-level
// scoreboard that checks every cycle's outputs.
module tb_mem_arb_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RD_LAT = 2;
  localparam int SYNC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          jtag_sel, jtag_we;
  logic [AW-1:0] jtag_addr;
  logic [DW-1:0] jtag_wdata;
  logic          jtag_ready;
  logic [DW-1:0] jtag_rdata;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gnt_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arb_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .SYNC_STAGES(SYNC)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .jtag_sel(jtag_sel), .jtag_we(jtag_we), .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
    .jtag_ready(jtag_ready), .jtag_rdata(jtag_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // SRAM model: data of a read appears RD_LAT cycles after its mem_ce cycle.
  logic [DW-1:0] sram [256];
  logic [DW-1:0] rd_pipe [RD_LAT];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) sram[pre_addr] <= pre_data;
    else if (mem_ce && mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_ce && !mem_we) rd_pipe[0] <= sram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: each granted access must reach the SRAM one cycle later, reads answer
  // RD_LAT+1 cycles after issue, JTAG read data only changes when a JTAG read completes.
  int            cpu_issue_at, cpu_rd_at, j_done_at;
  logic [24:0]   cpu_cmd_exp;
  logic [DW-1:0] cpu_rd_exp, j_rd_exp, jr_model;
  logic          j_rd_pending, prev_ce, prev_ready;

  always @(negedge clk) begin
    if (rst) begin
      cpu_issue_at = -1; cpu_rd_at = -1; j_done_at = -1;
      jr_model = '0; j_rd_pending = 1'b0; prev_ce = 1'b0; prev_ready = 1'b1;
    end else begin
      chk("ce_gap", 32'(prev_ce & mem_ce), 32'd0);
      if (cpu_issue_at == cyc) begin
        chk("cpu_issue_ce", 32'(mem_ce), 32'd1);
        chk("cpu_issue_cmd", 32'({mem_we, mem_addr, mem_wdata}), 32'(cpu_cmd_exp));
      end
      if (mem_ce) begin
        $display("[TB] access cyc=%0d %s we=%0d addr=%h wdata=%h", cyc,
                 (cpu_issue_at == cyc) ? "cpu " : "jtag", mem_we, mem_addr, mem_wdata);
        if (cpu_issue_at != cyc) begin
          chk("jtag_issue_cmd", 32'({mem_we, mem_addr, mem_wdata}),
              32'({jtag_we, jtag_addr, jtag_wdata}));
          j_done_at    = cyc + (mem_we ? 1 : RD_LAT + 1);
          j_rd_pending = !mem_we;
          j_rd_exp     = sram[mem_addr];
        end else if (!mem_we) begin
          cpu_rd_at  = cyc + RD_LAT + 1;
          cpu_rd_exp = sram[mem_addr];
        end
      end
      if (cpu_gnt) begin
        cpu_issue_at = cyc + 1;
        cpu_cmd_exp  = {cpu_we, cpu_addr, cpu_wdata};
      end
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(cpu_rd_at == cyc));
      if (cpu_rd_at == cyc) chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_rd_exp));
      if (j_done_at == cyc) begin
        chk("jtag_ready_rise", 32'({prev_ready, jtag_ready}), 32'd1);
        if (j_rd_pending) jr_model = j_rd_exp;
      end
      chk("jtag_rdata_hold", 32'(jtag_rdata), 32'(jr_model));
      prev_ce    = mem_ce;
      prev_ready = jtag_ready;
    end
  end

  always @(negedge clk) if (!rst && cpu_gnt) gnt_cnt <= gnt_cnt + 1;

  // kind: 0 mem_ce, 1 cpu_gnt, 2 jtag_ready low, 3 jtag_ready high, 4 cpu_rvalid
  task automatic wait_for(input int kind, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      case (kind)
        0: ok = mem_ce;
        1: ok = cpu_gnt;
        2: ok = !jtag_ready;
        3: ok = jtag_ready;
        default: ok = cpu_rvalid;
      endcase
    end
  endtask

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, g0, ce_seen;
    logic [AW-1:0] seq [2];

    rst = 1'b1; jtag_sel = 1'b0; jtag_we = 1'b0; jtag_addr = '0; jtag_wdata = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h34; cpu_wdata = '0;
    pre_we = 1'b1; pre_addr = 8'h34; pre_data = 16'h1234;
    drive_edge();
    pre_we = 1'b0;
    jtag_sel = 1'b1; jtag_we = 1'b1; jtag_addr = 8'h12; jtag_wdata = 16'hA5A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(jtag_ready), 32'd1);
    chk("rst_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_ce_we", 32'({mem_ce, mem_we, cpu_rvalid}), 32'd0);
    chk("rst_rdata", 32'({jtag_rdata, cpu_rdata}), 32'd0);
    chk("rst_mem_regs", 32'({mem_addr, mem_wdata}), 32'd0);
    drive_edge();
    rst = 1'b0; cpu_req = 1'b0;

    // 1: JTAG write accepted although jtag_sel was already high through reset
    wait_for(2, SYNC + 2, ok);
    chk("t1_ready_low", 32'(ok), 32'd1);
    wait_for(0, 10, ok);
    chk("t1_ce", 32'(ok), 32'd1);
    chk("t1_cmd", 32'({mem_we, mem_addr, mem_wdata}), 32'h112A5A5);
    wait_for(3, 10, ok);
    chk("t1_ready_back", 32'(ok), 32'd1);
    n = 0;
    repeat (8) begin @(negedge clk); n += int'(mem_ce); end
    chk("t1_no_retrigger", 32'(n), 32'd0);
    drive_edge(); jtag_sel = 1'b0;
    repeat (4) drive_edge();

    // 2: JTAG read back, held select must not start another access
    jtag_we = 1'b0; jtag_sel = 1'b1;
    wait_for(2, 10, ok);
    chk("t2_ready_low", 32'(ok), 32'd1);
    wait_for(3, 20, ok);
    chk("t2_ready_rise", 32'(ok), 32'd1);
    chk("t2_rdata", 32'(jtag_rdata), 32'hA5A5);
    n = 0;
    repeat (8) begin @(negedge clk); n += int'(mem_ce); end
    chk("t2_no_retrigger", 32'(n), 32'd0);
    drive_edge(); jtag_sel = 1'b0;
    repeat (4) drive_edge();

    // 3: CPU read latency with RD_LAT=2
    cpu_we = 1'b0; cpu_addr = 8'h34; cpu_req = 1'b1;
    wait_for(1, 10, ok);
    chk("t3_gnt", 32'(ok), 32'd1);
    drive_edge(); cpu_req = 1'b0;
    @(negedge clk);
    chk("t3_ce_t1", 32'({mem_ce, mem_we, mem_addr}), 32'h234);
    @(negedge clk);
    chk("t3_rvalid_t2", 32'(cpu_rvalid), 32'd0);
    @(negedge clk);
    chk("t3_rvalid_t3", 32'(cpu_rvalid), 32'd0);
    @(negedge clk);
    chk("t3_rvalid_t4", 32'(cpu_rvalid), 32'd1);
    chk("t3_rdata_t4", 32'(cpu_rdata), 32'h1234);

    // 4: simultaneous requests out of reset, then fairness under continuous cpu_req
    drive_edge();
    rst = 1'b1;
    jtag_sel = 1'b1; jtag_we = 1'b1; jtag_addr = 8'h56; jtag_wdata = 16'hBEEF;
    cpu_we = 1'b1; cpu_addr = 8'h57; cpu_wdata = 16'hCAFE;
    repeat (3) drive_edge();
    rst = 1'b0;
    wait_for(2, SYNC + 3, ok);
    chk("t4_jtag_pending", 32'(ok), 32'd1);
    #1 cpu_req = 1'b1;
    ce_seen = 0;
    for (int i = 0; i < 20 && ce_seen < 2; i++) begin
      @(negedge clk);
      if (mem_ce) begin seq[ce_seen] = mem_addr; ce_seen++; end
    end
    chk("t4_two_accesses", 32'(ce_seen), 32'd2);
    chk("t4_first_jtag", 32'(seq[0]), 32'h56);
    chk("t4_second_cpu", 32'(seq[1]), 32'h57);
    wait_for(3, 10, ok);
    drive_edge(); jtag_sel = 1'b0;
    repeat (3) drive_edge();
    jtag_addr = 8'h58; jtag_wdata = 16'h1111; jtag_sel = 1'b1;
    wait_for(2, 10, ok);
    chk("t4_fair_pending", 32'(ok), 32'd1);
    n = 0; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (mem_ce && mem_addr == 8'h58) ok = 1'b1;
      else if (mem_ce) n++;
    end
    chk("t4_fair_served", 32'(ok), 32'd1);
    chk("t4_fair_cpu_between", 32'(n > 1), 32'd0);
    drive_edge(); cpu_req = 1'b0;
    wait_for(3, 10, ok);
    drive_edge(); jtag_sel = 1'b0;
    repeat (4) drive_edge();

    // 5: reset while a CPU read waits for data drops it
    cpu_we = 1'b0; cpu_addr = 8'h34; cpu_req = 1'b1;
    wait_for(1, 10, ok);
    chk("t5_gnt", 32'(ok), 32'd1);
    drive_edge(); cpu_req = 1'b0;
    drive_edge(); rst = 1'b1;
    drive_edge(); rst = 1'b0;
    @(negedge clk);
    chk("t5_after_rst", 32'({mem_ce, jtag_ready}), 32'd1);
    n = 0;
    repeat (6) begin @(negedge clk); n += int'(cpu_rvalid); end
    chk("t5_no_rvalid", 32'(n), 32'd0);

    // 6: CPU write then read of the same address back-to-back
    drive_edge();
    g0 = gnt_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h9A; cpu_wdata = 16'h7E57;
    wait_for(1, 10, ok);
    chk("t6_wr_gnt", 32'(ok), 32'd1);
    drive_edge(); cpu_we = 1'b0;
    wait_for(1, 10, ok);
    chk("t6_rd_gnt", 32'(ok), 32'd1);
    drive_edge(); cpu_req = 1'b0;
    wait_for(4, 10, ok);
    chk("t6_rvalid", 32'(ok), 32'd1);
    chk("t6_rdata", 32'(cpu_rdata), 32'h7E57);
    repeat (4) drive_edge();
    chk("t6_gnt_count", 32'(gnt_cnt - g0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
